// File: rtl/soc_ifc_fw_rst_scheduler.sv
// Firmware-update-reset scheduler: round-robin arbitration of reset requests into single
// fw_update_rst handshakes with the boot FSM, with cooldown, timeout and abort handling.

package soc_ifc_fw_rst_pkg;
  typedef enum logic [2:0] {
    BOOT_IDLE   = 3'b000,
    BOOT_FUSE   = 3'b001,
    BOOT_FW_RST = 3'b010,
    BOOT_WAIT   = 3'b011,
    BOOT_DONE   = 3'b100
  } boot_fsm_state_e;
endpackage

module soc_ifc_fw_rst_scheduler
  import soc_ifc_fw_rst_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter logic [7:0]  MIN_WAIT_CYCLES = 8'd5,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  localparam int unsigned IDW            = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sched_en,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_wait_cycles,
  input  boot_fsm_state_e        boot_fsm_ps,
  input  logic                   err_clr,
  output logic                   fw_update_rst,
  output logic [7:0]             fw_update_rst_wait_cycles,
  output logic                   gnt_vld,
  output logic [IDW-1:0]         gnt_id,
  output logic [NUM_REQ-1:0]     pending,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err_timeout
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CD_LAST  = 16'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ASSERT    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_COOLDOWN  = 2'd3
  } sched_state_e;

  sched_state_e       state, state_d;
  logic [IDW-1:0]     rr_ptr, rr_d;
  logic [15:0]        tmo_cnt, tmo_d;
  logic [15:0]        cd_cnt, cd_d;
  logic               fw_d, gnt_vld_d, err_set;
  logic [IDW-1:0]     gnt_id_d, win_id;
  logic [7:0]         wait_d, wait_sel;
  logic [NUM_REQ-1:0] done_d, clr_d;

  // First pending source at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] p,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int unsigned    idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && p[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
    return pick;
  endfunction

  assign win_id   = rr_pick(pending, rr_ptr);
  assign wait_sel = req_wait_cycles[8*win_id +: 8];

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through the case infers a latch.
    state_d   = state;
    fw_d      = fw_update_rst;
    gnt_vld_d = gnt_vld;
    gnt_id_d  = gnt_id;
    wait_d    = fw_update_rst_wait_cycles;
    rr_d      = rr_ptr;
    tmo_d     = tmo_cnt;
    cd_d      = cd_cnt;
    done_d    = '0;
    clr_d     = '0;
    err_set   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (sched_en && (|pending) && boot_fsm_ps == BOOT_DONE) begin
          state_d   = S_ASSERT;
          fw_d      = 1'b1;
          gnt_vld_d = 1'b1;
          gnt_id_d  = win_id;
          wait_d    = (wait_sel < MIN_WAIT_CYCLES) ? MIN_WAIT_CYCLES : wait_sel;
          rr_d      = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          tmo_d     = '0;
        end
      end

      S_ASSERT, S_WAIT_DONE: begin
        tmo_d = tmo_cnt + 16'd1;
        // Warm/cold reset of the SoC: drop the grant but keep the request queued.
        if (boot_fsm_ps == BOOT_IDLE || boot_fsm_ps == BOOT_FUSE) begin
          state_d   = S_IDLE;
          fw_d      = 1'b0;
          gnt_vld_d = 1'b0;
          tmo_d     = '0;
        end else if (state == S_ASSERT && boot_fsm_ps == BOOT_FW_RST) begin
          state_d = S_WAIT_DONE;
          fw_d    = 1'b0;
          tmo_d   = '0;
        end else if (state == S_WAIT_DONE && boot_fsm_ps == BOOT_DONE) begin
          state_d         = S_COOLDOWN;
          gnt_vld_d       = 1'b0;
          done_d[gnt_id]  = 1'b1;
          clr_d[gnt_id]   = 1'b1;
          cd_d            = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d       = S_COOLDOWN;
          fw_d          = 1'b0;
          gnt_vld_d     = 1'b0;
          err_set       = 1'b1;
          clr_d[gnt_id] = 1'b1;
          cd_d          = '0;
        end
      end

      S_COOLDOWN: begin
        if (cd_cnt == CD_LAST) begin
          state_d = S_IDLE;
          cd_d    = '0;
        end else begin
          cd_d = cd_cnt + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= S_IDLE;
      rr_ptr                    <= '0;
      tmo_cnt                   <= '0;
      cd_cnt                    <= '0;
      fw_update_rst             <= 1'b0;
      fw_update_rst_wait_cycles <= '0;
      gnt_vld                   <= 1'b0;
      gnt_id                    <= '0;
      pending                   <= '0;
      done                      <= '0;
      err_timeout               <= 1'b0;
    end else begin
      state                     <= state_d;
      rr_ptr                    <= rr_d;
      tmo_cnt                   <= tmo_d;
      cd_cnt                    <= cd_d;
      fw_update_rst             <= fw_d;
      fw_update_rst_wait_cycles <= wait_d;
      gnt_vld                   <= gnt_vld_d;
      gnt_id                    <= gnt_id_d;
      // A new request in the same cycle as a completion keeps the bit set.
      pending                   <= (pending & ~clr_d) | req;
      done                      <= done_d;
      if (err_set)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_soc_ifc_fw_rst_scheduler.sv
// Self-checking bench: boot FSM model plus a completion scoreboard for the reset scheduler.

module tb_soc_ifc_fw_rst_scheduler;
  import soc_ifc_fw_rst_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sched_en = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_wait_cycles = '0;
  logic        err_clr = 1'b0;
  boot_fsm_state_e boot_fsm_ps = BOOT_IDLE;

  logic        fw_update_rst;
  logic [7:0]  fw_update_rst_wait_cycles;
  logic        gnt_vld;
  logic [1:0]  gnt_id;
  logic [2:0]  pending;
  logic [2:0]  done;
  logic        err_timeout;

  always #5 clk = ~clk;

  soc_ifc_fw_rst_scheduler dut (
    .clk                       (clk),
    .rst                       (rst),
    .sched_en                  (sched_en),
    .req                       (req),
    .req_wait_cycles           (req_wait_cycles),
    .boot_fsm_ps               (boot_fsm_ps),
    .err_clr                   (err_clr),
    .fw_update_rst             (fw_update_rst),
    .fw_update_rst_wait_cycles (fw_update_rst_wait_cycles),
    .gnt_vld                   (gnt_vld),
    .gnt_id                    (gnt_id),
    .pending                   (pending),
    .done                      (done),
    .err_timeout               (err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_wait(input logic [7:0] w);
    return (w < 8'd5) ? 8'd5 : w;
  endfunction

  typedef struct {
    int         id;
    logic [7:0] wcyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int id, input logic [7:0] w);
    exp_t e;
    e.id   = id;
    e.wcyc = exp_wait(w);
    exp_q.push_back(e);
  endtask

  // Boot FSM model: DONE -> FW_RST two cycles after the request, hold WAIT for the wait count.
  bit              model_en = 1'b1;
  boot_fsm_state_e force_state = BOOT_DONE;
  int              m_cnt = 0;

  always @(negedge clk) begin
    if (!model_en) begin
      boot_fsm_ps = force_state;
      m_cnt       = 0;
    end else begin
      case (boot_fsm_ps)
        BOOT_DONE: begin
          if (fw_update_rst) begin
            if (m_cnt >= 1) begin
              boot_fsm_ps = BOOT_FW_RST;
              m_cnt       = 0;
            end else m_cnt++;
          end else m_cnt = 0;
        end
        BOOT_FW_RST: begin
          boot_fsm_ps = BOOT_WAIT;
          m_cnt       = int'(fw_update_rst_wait_cycles);
        end
        BOOT_WAIT: begin
          if (m_cnt <= 1) boot_fsm_ps = BOOT_DONE;
          else m_cnt--;
        end
        default: boot_fsm_ps = BOOT_DONE;
      endcase
    end
  end

  // Monitor: capture each grant, pop the scoreboard on every done pulse.
  logic       fw_q = 1'b0;
  int         cyc = 0, fall_cyc = 0, done_cnt = 0, rise_cnt = 0, cap_id = 0;
  bit         armed = 1'b0;
  logic [7:0] cap_wait = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (fw_update_rst && !fw_q) begin
      rise_cnt++;
      cap_wait = fw_update_rst_wait_cycles;
      cap_id   = int'(gnt_id);
      if (armed) begin
        check("cooldown_gap", 32'((cyc - fall_cyc) >= 17), 32'd1);
        armed = 1'b0;
      end
    end
    if (|done) begin
      done_cnt++;
      armed    = 1'b1;
      fall_cyc = cyc;
      check("done_gnt_vld", 32'(gnt_vld), 32'd0);
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_onehot", 32'(done), 32'(3'b001 << e.id));
        check("grant_id", 32'(cap_id), 32'(e.id));
        check("wait_cycles", 32'(cap_wait), 32'(e.wcyc));
        check("wait_hold", 32'(fw_update_rst_wait_cycles), 32'(e.wcyc));
      end
    end
    if (rst) armed = 1'b0;
    fw_q = fw_update_rst;
  end

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_fw_rise(input int budget, input string tag, output int waited);
    waited = 0;
    while (!fw_update_rst && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check(tag, 32'(fw_update_rst), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_fw"},    32'(fw_update_rst), 32'd0);
    check({pfx, "_wait"},  32'(fw_update_rst_wait_cycles), 32'd0);
    check({pfx, "_gvld"},  32'(gnt_vld), 32'd0);
    check({pfx, "_gid"},   32'(gnt_id), 32'd0);
    check({pfx, "_pend"},  32'(pending), 32'd0);
    check({pfx, "_done"},  32'(done), 32'd0);
    check({pfx, "_err"},   32'(err_timeout), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, d0, r0;

    // Reset state
    idle(3);
    check_all_zero("rst");
    rst = 1'b0;
    idle(3);

    // 1: single request, latency N+2, wait count, one done pulse
    req_wait_cycles = {8'd0, 8'd0, 8'd10};
    push_exp(0, 8'd10);
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    req = 3'b000;
    check("t1_pending", 32'(pending), 32'd1);
    check("t1_fw_n1", 32'(fw_update_rst), 32'd0);
    @(negedge clk);
    check("t1_fw_n2", 32'(fw_update_rst), 32'd1);
    check("t1_gvld", 32'(gnt_vld), 32'd1);
    check("t1_wait", 32'(fw_update_rst_wait_cycles), 32'd10);
    wait_done(1, 200, "t1_done");
    check("t1_pend_clr", 32'(pending), 32'd0);
    check("t1_fw_low", 32'(fw_update_rst), 32'd0);
    idle(20);
    check("t1_single_done", 32'(done_cnt), 32'd1);

    // 2/3: simultaneous requests from reset, then a second round after rr_ptr wraps
    do_reset();
    req_wait_cycles = {8'd40, 8'd2, 8'd7};
    push_exp(0, 8'd7);
    push_exp(1, 8'd2);
    push_exp(2, 8'd40);
    @(negedge clk);
    req = 3'b111;
    @(negedge clk);
    req = 3'b000;
    check("t2_pending", 32'(pending), 32'd7);
    wait_done(4, 600, "t2_round1");
    idle(20);
    push_exp(0, 8'd7);
    push_exp(1, 8'd2);
    push_exp(2, 8'd40);
    @(negedge clk);
    req = 3'b111;
    @(negedge clk);
    req = 3'b000;
    wait_done(7, 600, "t2_round2");
    idle(20);

    // 4: boot FSM stuck in DONE -> timeout, pending cleared, no done
    model_en    = 1'b0;
    force_state = BOOT_DONE;
    d0 = done_cnt;
    @(negedge clk);
    req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    wait_fw_rise(10, "t4_grant", waited);
    check("t4_gnt_id", 32'(gnt_id), 32'd1);
    waited = 0;
    while (!err_timeout && waited < 1100) begin
      @(negedge clk);
      waited++;
    end
    check("t4_tmo_latency", 32'(waited), 32'd1024);
    check("t4_pend_clr", 32'(pending), 32'd0);
    check("t4_fw_low", 32'(fw_update_rst), 32'd0);
    check("t4_gvld_low", 32'(gnt_vld), 32'd0);
    idle(5);
    check("t4_err_sticky", 32'(err_timeout), 32'd1);
    check("t4_no_done", 32'(done_cnt), 32'(d0));
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", 32'(err_timeout), 32'd0);
    idle(20);

    // 5: abort to BOOT_IDLE during WAIT_DONE, pending kept, reissued once
    model_en = 1'b1;
    idle(2);
    d0 = done_cnt;
    push_exp(2, 8'd40);
    @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    req = 3'b000;
    waited = 0;
    while (boot_fsm_ps != BOOT_WAIT && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("t5_in_wait", 32'(boot_fsm_ps == BOOT_WAIT), 32'd1);
    force_state = BOOT_IDLE;
    model_en    = 1'b0;
    idle(4);
    check("t5_gvld_abort", 32'(gnt_vld), 32'd0);
    check("t5_fw_abort", 32'(fw_update_rst), 32'd0);
    check("t5_pend_kept", 32'(pending), 32'd4);
    check("t5_no_done", 32'(done_cnt), 32'(d0));
    force_state = BOOT_DONE;
    idle(2);
    model_en = 1'b1;
    wait_done(d0 + 1, 300, "t5_reissue");
    idle(40);
    check("t5_one_done", 32'(done_cnt), 32'(d0 + 1));
    check("t5_pend_clr", 32'(pending), 32'd0);

    // 6: sched_en gating, then synchronous reset mid-ASSERT
    model_en    = 1'b0;
    force_state = BOOT_DONE;
    sched_en    = 1'b0;
    r0 = rise_cnt;
    @(negedge clk);
    req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    idle(30);
    check("t6_no_grant", 32'(rise_cnt), 32'(r0));
    check("t6_pending", 32'(pending), 32'd2);
    sched_en = 1'b1;
    wait_fw_rise(10, "t6_grant", waited);
    check("t6_gnt_id", 32'(gnt_id), 32'd1);
    check("t6_wait", 32'(fw_update_rst_wait_cycles), 32'd5);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("t6_rst");

    idle(5);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
